// File: rtl/pixel_mem_scheduler.sv
// Arbitrates the single-port image RAM between display fetches (absolute priority)
// and decryptor loads/stores; routes the synchronous read data back one cycle later.
module pixel_mem_scheduler #(
    parameter int DATA_W     = 8,
    parameter int STRIDE_ENC = 640,
    parameter int STRIDE_DEC = 320
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pix_en,
    input  logic              i_video_on,
    input  logic [9:0]        i_pos_x,
    input  logic [9:0]        i_pos_y,
    input  logic              i_chg_img,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_pix_valid,
    input  logic              i_dec_req,
    input  logic              i_dec_we,
    input  logic [31:0]       i_dec_addr,
    input  logic [DATA_W-1:0] i_dec_wdata,
    output logic              o_dec_gnt,
    output logic              o_dec_rvalid,
    output logic [DATA_W-1:0] o_dec_rdata,
    output logic [31:0]       o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_img_sel
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISP_RD,
        ST_DEC_RD,
        ST_DEC_WR
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [31:0]         r_last_addr;
    logic                r_img_sel;
    logic                r_blank_pend;
    logic [DATA_W-1:0]   r_pix_data;
    logic                r_pix_valid;
    logic [DATA_W-1:0]   r_dec_rdata;
    logic                r_dec_rvalid;

    logic                w_frame_start;
    logic                w_img_eff;
    logic [31:0]         w_stride;
    logic [16:0]         w_off;
    logic [31:0]         w_disp_addr;
    logic                w_disp_rd;
    logic                w_blank;
    logic [31:0]         w_mem_addr;
    logic                w_mem_we;
    logic                w_dec_gnt;

    // The frame-start fetch already uses the newly requested image, so a switch never tears.
    assign w_frame_start = i_pix_en && (i_pos_x == 10'd0) && (i_pos_y == 10'd0);
    assign w_img_eff     = w_frame_start ? i_chg_img : r_img_sel;
    assign w_stride      = w_img_eff ? 32'(STRIDE_DEC) : 32'(STRIDE_ENC);
    assign w_off         = 17'(w_stride * {22'd0, i_pos_y} + {22'd0, i_pos_x});
    assign w_disp_addr   = {14'd0, w_img_eff, w_off};

    assign w_disp_rd = i_pix_en & i_video_on;
    assign w_blank   = i_pix_en & ~i_video_on;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_IDLE;
        w_mem_addr   = r_last_addr;
        w_mem_we     = 1'b0;
        w_dec_gnt    = 1'b0;
        if (w_disp_rd) begin
            w_state_next = ST_DISP_RD;
            w_mem_addr   = w_disp_addr;
        end else if (i_dec_req) begin
            w_state_next = i_dec_we ? ST_DEC_WR : ST_DEC_RD;
            w_mem_addr   = i_dec_addr;
            w_mem_we     = i_dec_we;
            w_dec_gnt    = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_addr  <= '0;
            r_img_sel    <= 1'b0;
            r_blank_pend <= 1'b0;
            r_pix_data   <= '0;
            r_pix_valid  <= 1'b0;
            r_dec_rdata  <= '0;
            r_dec_rvalid <= 1'b0;
        end else begin
            r_last_addr  <= w_mem_addr;
            r_blank_pend <= w_blank;
            if (w_frame_start) begin
                r_img_sel <= i_chg_img;
            end
            // Blanking positions never touch the RAM but still emit a black pixel.
            r_pix_valid <= (r_state == ST_DISP_RD) | r_blank_pend;
            if (r_state == ST_DISP_RD) begin
                r_pix_data <= i_mem_rdata;
            end else if (r_blank_pend) begin
                r_pix_data <= '0;
            end
            r_dec_rvalid <= (r_state == ST_DEC_RD);
            if (r_state == ST_DEC_RD) begin
                r_dec_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_mem_addr   = w_mem_addr;
    assign o_mem_we     = w_mem_we;
    assign o_mem_wdata  = i_dec_wdata;
    assign o_dec_gnt    = w_dec_gnt;
    assign o_pix_data   = r_pix_data;
    assign o_pix_valid  = r_pix_valid;
    assign o_dec_rdata  = r_dec_rdata;
    assign o_dec_rvalid = r_dec_rvalid;
    assign o_img_sel    = r_img_sel;

endmodule

// File: tb/tb_pixel_mem_scheduler.sv
// Randomized and directed bench for pixel_mem_scheduler against a cycle-level
// arbitration model and a synchronous RAM model.
module tb_pixel_mem_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        chg_img = 1'b0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        dec_req = 1'b0;
    logic        dec_we = 1'b0;
    logic [31:0] dec_addr = '0;
    logic [7:0]  dec_wdata = '0;
    logic        dec_gnt;
    logic        dec_rvalid;
    logic [7:0]  dec_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        img_sel;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram [0:262143];

    pixel_mem_scheduler #(.DATA_W(8), .STRIDE_ENC(640), .STRIDE_DEC(320)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_video_on(video_on),
        .i_pos_x(pos_x), .i_pos_y(pos_y), .i_chg_img(chg_img),
        .o_pix_data(pix_data), .o_pix_valid(pix_valid),
        .i_dec_req(dec_req), .i_dec_we(dec_we), .i_dec_addr(dec_addr),
        .i_dec_wdata(dec_wdata), .o_dec_gnt(dec_gnt), .o_dec_rvalid(dec_rvalid),
        .o_dec_rdata(dec_rdata), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_img_sel(img_sel)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data valid the cycle after the address.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr[17:0]];
        if (mem_we) ram[mem_addr[17:0]] <= mem_wdata;
    end

    function automatic logic [7:0] ram_rd(input logic [17:0] a);
        return ram[a];
    endfunction

    function automatic logic [31:0] disp_addr(input logic img, input int x, input int y);
        int stride;
        int off;
        stride = img ? 320 : 640;
        off = (stride * y + x) % 131072;
        return 32'(off) + (img ? 32'h0002_0000 : 32'h0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        pix_en = 1'b0; video_on = 1'b0; dec_req = 1'b0; dec_we = 1'b0;
    endtask

    task automatic test_reset;
        idle_in();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++; if (pix_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pix_valid got=%b exp=0", pix_valid); end
        n_checks++; if (pix_data !== 8'h00) begin n_errors++; $display("FAIL reset_pix_data got=%h exp=00", pix_data); end
        n_checks++; if (dec_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_dec_rvalid got=%b exp=0", dec_rvalid); end
        n_checks++; if (dec_rdata !== 8'h00) begin n_errors++; $display("FAIL reset_dec_rdata got=%h exp=00", dec_rdata); end
        n_checks++; if (img_sel !== 1'b0) begin n_errors++; $display("FAIL reset_img_sel got=%b exp=0", img_sel); end
        n_checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_mem got we=%b addr=%h exp we=0 addr=0", mem_we, mem_addr); end
        // Switch image, then reset in the middle of a decryptor read.
        pix_en = 1'b1; video_on = 1'b1; pos_x = 10'd0; pos_y = 10'd0; chg_img = 1'b1;
        tick();
        pix_en = 1'b0;
        n_checks++; if (img_sel !== 1'b1) begin n_errors++; $display("FAIL pre_reset_img_sel got=%b exp=1", img_sel); end
        dec_req = 1'b1; dec_we = 1'b0; dec_addr = 32'h123;
        tick();
        dec_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pix_valid !== 1'b0 || pix_data !== 8'h00) begin n_errors++; $display("FAIL midreset_pix got valid=%b data=%h exp 0/00", pix_valid, pix_data); end
        n_checks++; if (img_sel !== 1'b0) begin n_errors++; $display("FAIL midreset_img_sel got=%b exp=0", img_sel); end
        @(posedge clk);
        #1 rst_n = 1'b1; chg_img = 1'b0;
        tick();
        n_checks++; if (dec_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_dropped_read got rvalid=%b exp=0", dec_rvalid); end
        $display("reset: done");
    endtask

    task automatic test_enc_addr;
        pix_en = 1'b1; video_on = 1'b1; pos_x = 10'd5; pos_y = 10'd2;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h0000_0505 || mem_we !== 1'b0 || dec_gnt !== 1'b0) begin n_errors++; $display("FAIL enc_addr got addr=%h we=%b gnt=%b exp addr=00000505 we=0 gnt=0", mem_addr, mem_we, dec_gnt); end
        tick();
        pix_en = 1'b0;
        n_checks++; if (pix_valid !== 1'b0) begin n_errors++; $display("FAIL enc_early_valid got=%b exp=0", pix_valid); end
        tick();
        n_checks++; if (pix_valid !== 1'b1 || pix_data !== 8'hA5) begin n_errors++; $display("FAIL enc_pixel got valid=%b data=%h exp 1/a5", pix_valid, pix_data); end
        tick();
        n_checks++; if (pix_valid !== 1'b0) begin n_errors++; $display("FAIL enc_valid_pulse got=%b exp=0", pix_valid); end
        $display("enc_addr: addr=%h pix=%h", 32'h505, pix_data);
    endtask

    task automatic test_image_switch;
        chg_img = 1'b1; pix_en = 1'b1; video_on = 1'b1; pos_x = 10'd7; pos_y = 10'd3;
        tick();
        pix_en = 1'b0;
        n_checks++; if (img_sel !== 1'b0) begin n_errors++; $display("FAIL midframe_img_sel got=%b exp=0", img_sel); end
        tick();
        pix_en = 1'b1; pos_x = 10'd0; pos_y = 10'd0;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h0002_0000) begin n_errors++; $display("FAIL frame_start_addr got=%h exp=00020000", mem_addr); end
        tick();
        pix_en = 1'b0; chg_img = 1'b0;
        n_checks++; if (img_sel !== 1'b1) begin n_errors++; $display("FAIL frame_start_img_sel got=%b exp=1", img_sel); end
        tick();
        pix_en = 1'b1; pos_x = 10'd5; pos_y = 10'd2;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h0002_0285) begin n_errors++; $display("FAIL dec_img_addr got=%h exp=00020285", mem_addr); end
        tick();
        pix_en = 1'b0;
        n_checks++; if (img_sel !== 1'b1) begin n_errors++; $display("FAIL img_sel_hold got=%b exp=1", img_sel); end
        tick();
        n_checks++; if (pix_data !== ram_rd(18'h20285)) begin n_errors++; $display("FAIL dec_img_pixel got=%h exp=%h", pix_data, ram_rd(18'h20285)); end
        pix_en = 1'b1; pos_x = 10'd0; pos_y = 10'd0; chg_img = 1'b0;
        tick();
        pix_en = 1'b0;
        n_checks++; if (img_sel !== 1'b0) begin n_errors++; $display("FAIL img_restore got=%b exp=0", img_sel); end
        tick();
        $display("image_switch: done");
    endtask

    task automatic test_truncation;
        pix_en = 1'b1; video_on = 1'b1; pos_x = 10'd0; pos_y = 10'd300;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h0000_EE00) begin n_errors++; $display("FAIL trunc_300 got=%h exp=0000ee00", mem_addr); end
        tick();
        pos_x = 10'd639; pos_y = 10'd479;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h0000_AFFF) begin n_errors++; $display("FAIL trunc_corner got=%h exp=0000afff", mem_addr); end
        tick();
        pix_en = 1'b0;
        tick();
        tick();
        $display("truncation: done");
    endtask

    task automatic test_collision;
        logic [7:0] exp_rd;
        logic [31:0] da;
        da = disp_addr(1'b0, 10, 4);
        pix_en = 1'b1; video_on = 1'b1; pos_x = 10'd10; pos_y = 10'd4;
        dec_req = 1'b1; dec_we = 1'b0; dec_addr = 32'h0002_0010;
        @(negedge clk);
        n_checks++; if (dec_gnt !== 1'b0 || mem_addr !== da) begin n_errors++; $display("FAIL collision_disp got gnt=%b addr=%h exp gnt=0 addr=%h", dec_gnt, mem_addr, da); end
        tick();
        pix_en = 1'b0;
        @(negedge clk);
        n_checks++; if (dec_gnt !== 1'b1 || mem_addr !== 32'h0002_0010 || mem_we !== 1'b0) begin n_errors++; $display("FAIL collision_gnt got gnt=%b addr=%h we=%b exp 1/00020010/0", dec_gnt, mem_addr, mem_we); end
        exp_rd = ram_rd(18'h20010);
        tick();
        dec_req = 1'b0;
        n_checks++; if (pix_valid !== 1'b1 || pix_data !== ram_rd(da[17:0])) begin n_errors++; $display("FAIL collision_pixel got valid=%b data=%h exp 1/%h", pix_valid, pix_data, ram_rd(da[17:0])); end
        tick();
        n_checks++; if (dec_rvalid !== 1'b1 || dec_rdata !== exp_rd) begin n_errors++; $display("FAIL collision_rdata got rvalid=%b data=%h exp 1/%h", dec_rvalid, dec_rdata, exp_rd); end
        tick();
        n_checks++; if (dec_rvalid !== 1'b0 || dec_rdata !== exp_rd) begin n_errors++; $display("FAIL rdata_hold got rvalid=%b data=%h exp 0/%h", dec_rvalid, dec_rdata, exp_rd); end
        $display("collision: rdata=%h", exp_rd);
    endtask

    task automatic test_blank_burst;
        logic [31:0] addrs [4];
        logic [7:0]  wds [4];
        video_on = 1'b0; pix_en = 1'b0; dec_req = 1'b1; dec_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addrs[i] = 32'h1000 + 32'(i * 3) + 32'($urandom_range(0, 2));
            wds[i] = 8'($urandom);
            dec_addr = addrs[i]; dec_wdata = wds[i];
            @(negedge clk);
            n_checks++; if (dec_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== addrs[i] || mem_wdata !== wds[i]) begin n_errors++; $display("FAIL burst_wr%0d got gnt=%b we=%b addr=%h wd=%h exp 1/1/%h/%h", i, dec_gnt, mem_we, mem_addr, mem_wdata, addrs[i], wds[i]); end
            tick();
            n_checks++; if (dec_rvalid !== 1'b0) begin n_errors++; $display("FAIL burst_rvalid%0d got=%b exp=0", i, dec_rvalid); end
        end
        dec_req = 1'b0; dec_we = 1'b0;
        pix_en = 1'b1; pos_x = 10'($urandom_range(0, 639)); pos_y = 10'($urandom_range(0, 479));
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b0 || dec_gnt !== 1'b0 || mem_addr !== addrs[3]) begin n_errors++; $display("FAIL blank_noaccess got we=%b gnt=%b addr=%h exp 0/0/%h", mem_we, dec_gnt, mem_addr, addrs[3]); end
        tick();
        pix_en = 1'b0;
        tick();
        n_checks++; if (pix_valid !== 1'b1 || pix_data !== 8'h00) begin n_errors++; $display("FAIL blank_pixel got valid=%b data=%h exp 1/00", pix_valid, pix_data); end
        dec_req = 1'b1; dec_we = 1'b0; dec_addr = addrs[2];
        tick();
        dec_req = 1'b0;
        tick();
        n_checks++; if (dec_rvalid !== 1'b1 || dec_rdata !== wds[2]) begin n_errors++; $display("FAIL burst_readback got rvalid=%b data=%h exp 1/%h", dec_rvalid, dec_rdata, wds[2]); end
        tick();
        tick();
        $display("blank_burst: wrote %h..%h", addrs[0], addrs[3]);
    endtask

    task automatic test_random;
        logic        pend = 1'b0;
        logic        p_we = 1'b0;
        logic [31:0] p_addr = '0;
        logic [7:0]  p_wd = '0;
        logic        m_img = 1'b0;
        logic [31:0] m_last = '0;
        logic        last_known = 1'b0;
        logic        prev_pv = 1'b0, prev_rv = 1'b0;
        logic [7:0]  prev_pd = '0, prev_rd = '0;
        logic        pd_known = 1'b0, rd_known = 1'b0;
        logic [7:0]  m_pd = '0, m_rd = '0;
        logic        c_pv, c_rv, disp, gnt, img_e, exp_we;
        logic [7:0]  c_pd, c_rd;
        logic [31:0] exp_addr;
        int x, y, grants;
        grants = 0;
        for (int k = 0; k < 400; k++) begin
            if (!pend && $urandom_range(0, 1) == 1) begin
                pend = 1'b1; p_we = 1'($urandom_range(0, 1));
                p_addr = 32'($urandom_range(0, 63)); p_wd = 8'($urandom);
            end
            dec_req = pend; dec_we = p_we; dec_addr = p_addr; dec_wdata = p_wd;
            pix_en = ($urandom_range(0, 2) == 0);
            video_on = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin x = 0; y = 0; end
            else begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
            pos_x = 10'(x); pos_y = 10'(y);
            chg_img = 1'($urandom_range(0, 1));
            img_e = (pix_en && x == 0 && y == 0) ? chg_img : m_img;
            disp = pix_en && video_on;
            gnt = !disp && pend;
            exp_addr = disp ? disp_addr(img_e, x, y) : (gnt ? p_addr : m_last);
            exp_we = gnt && p_we;
            @(negedge clk);
            n_checks++; if (dec_gnt !== gnt || mem_we !== exp_we) begin n_errors++; $display("FAIL rnd_arb%0d got gnt=%b we=%b exp gnt=%b we=%b", k, dec_gnt, mem_we, gnt, exp_we); end
            if (disp || gnt || last_known) begin
                n_checks++; if (mem_addr !== exp_addr) begin n_errors++; $display("FAIL rnd_addr%0d got=%h exp=%h", k, mem_addr, exp_addr); end
            end
            if (exp_we) begin
                n_checks++; if (mem_wdata !== p_wd) begin n_errors++; $display("FAIL rnd_wdata%0d got=%h exp=%h", k, mem_wdata, p_wd); end
            end
            c_pv = pix_en;
            c_pd = disp ? ram_rd(exp_addr[17:0]) : 8'h00;
            c_rv = gnt && !p_we;
            c_rd = ram_rd(p_addr[17:0]);
            if (disp || gnt) last_known = 1'b1;
            m_last = exp_addr;
            m_img = img_e;
            if (gnt) begin pend = 1'b0; grants++; end
            tick();
            if (prev_pv) begin pd_known = 1'b1; m_pd = prev_pd; end
            if (prev_rv) begin rd_known = 1'b1; m_rd = prev_rd; end
            n_checks++; if (pix_valid !== prev_pv || dec_rvalid !== prev_rv) begin n_errors++; $display("FAIL rnd_valid%0d got pv=%b rv=%b exp pv=%b rv=%b", k, pix_valid, dec_rvalid, prev_pv, prev_rv); end
            if (pd_known) begin
                n_checks++; if (pix_data !== m_pd) begin n_errors++; $display("FAIL rnd_pix%0d got=%h exp=%h", k, pix_data, m_pd); end
            end
            if (rd_known) begin
                n_checks++; if (dec_rdata !== m_rd) begin n_errors++; $display("FAIL rnd_rdata%0d got=%h exp=%h", k, dec_rdata, m_rd); end
            end
            n_checks++; if (img_sel !== m_img) begin n_errors++; $display("FAIL rnd_img%0d got=%b exp=%b", k, img_sel, m_img); end
            prev_pv = c_pv; prev_pd = c_pd; prev_rv = c_rv; prev_rd = c_rd;
        end
        idle_in();
        tick();
        $display("random: 400 cycles, %0d decryptor grants", grants);
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) begin
            ram[i] = 8'(i) ^ {6'(i >> 10), 2'(i >> 16)} ^ 8'h5A;
        end
        ram[18'h505] = 8'hA5;
        test_reset();
        test_enc_addr();
        test_image_switch();
        test_truncation();
        test_collision();
        test_blank_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
